// File: rtl/point_scalar_mult_pkg.sv
// Shared types for the scalar-multiplication slice: element width, point record
// and the controller state encoding.
package point_scalar_mult_pkg;

    localparam int WIDTH      = 193;
    localparam int KW_DEFAULT = 152;

    typedef logic [WIDTH:0] elem_t;

    typedef struct packed {
        elem_t x;
        elem_t y;
        logic  zero;
    } point_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_DBL_START = 3'd1,
        ST_DBL_WAIT  = 3'd2,
        ST_ADD_START = 3'd3,
        ST_ADD_WAIT  = 3'd4,
        ST_FINISH    = 3'd5
    } state_t;

    function automatic logic is_start(input state_t s);
        return (s == ST_DBL_START) || (s == ST_ADD_START);
    endfunction

endpackage

// File: rtl/point_add.sv
// Point-addition unit with the datapath handshake: reset starts a call, done rises
// LATENCY-1 cycles after reset falls and holds with the result until the next reset.
// The combine is an additive-group law with O as identity, standing in for the curve law.
module point_add
    import point_scalar_mult_pkg::*;
#(
    parameter int LATENCY = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [WIDTH:0] x1,
    input  logic [WIDTH:0] y1,
    input  logic           zero1,
    input  logic [WIDTH:0] x2,
    input  logic [WIDTH:0] y2,
    input  logic           zero2,
    output logic           done,
    output logic [WIDTH:0] x3,
    output logic [WIDTH:0] y3,
    output logic           zero3
);

    localparam int CNTW = $clog2(LATENCY + 1);

    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            done_q, done_d;
    point_t          res_q, res_d;
    point_t          sum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
            res_q  <= '0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
            res_q  <= res_d;
        end
    end

    always_comb begin
        if (zero1) begin
            sum = '{x: x2, y: y2, zero: zero2};
        end else if (zero2) begin
            sum = '{x: x1, y: y1, zero: zero1};
        end else begin
            sum = '{x: x1 + x2, y: y1 + y2, zero: 1'b0};
        end
    end

    always_comb begin
        cnt_d  = cnt_q;
        done_d = done_q;
        res_d  = res_q;
        if (!done_q) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNTW'(LATENCY - 2)) begin
                done_d = 1'b1;
                res_d  = sum;
            end
        end
    end

    assign done  = done_q;
    assign x3    = res_q.x;
    assign y3    = res_q.y;
    assign zero3 = res_q.zero;

endmodule

// File: rtl/point_scalar_mult.sv
// Left-to-right double-and-add scalar multiplier Q = k*P, sequencing one point_add
// instance through doubling and addition calls.
module point_scalar_mult
    import point_scalar_mult_pkg::*;
#(
    parameter int KW      = KW_DEFAULT,
    parameter int PA_WAIT = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [KW-1:0]  k,
    input  logic [WIDTH:0] x,
    input  logic [WIDTH:0] y,
    input  logic           zero,
    output logic           busy,
    output logic           done,
    output logic [WIDTH:0] x_out,
    output logic [WIDTH:0] y_out,
    output logic           zero_out
);

    localparam int CW = $clog2(KW + 1);

    state_t          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    point_t          p_q, p_d;
    point_t          r_q, r_d;
    point_t          out_q, out_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            pa_reset_q, pa_reset_d;

    logic            pa_done;
    logic [WIDTH:0]  pa_x3, pa_y3;
    logic            pa_zero3;
    point_t          pa_res;
    point_t          op1, op2;
    logic            last_bit;
    logic            capture;
    logic            advance;

    // Handshake with point_add: pa_reset is high for exactly the START cycle, with
    // operands already driven from registers; operands then hold through every WAIT
    // cycle, and the result is captured in the WAIT cycle where pa_done is 1.
    assign op1    = r_q;
    assign op2    = (state_q == ST_ADD_START || state_q == ST_ADD_WAIT) ? p_q : r_q;
    assign pa_res = '{x: pa_x3, y: pa_y3, zero: pa_zero3};

    point_add #(.LATENCY(PA_WAIT)) ins_pa (
        .clk   (clk),
        .reset (pa_reset_q),
        .x1    (op1.x),
        .y1    (op1.y),
        .zero1 (op1.zero),
        .x2    (op2.x),
        .y2    (op2.y),
        .zero2 (op2.zero),
        .done  (pa_done),
        .x3    (pa_x3),
        .y3    (pa_y3),
        .zero3 (pa_zero3)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            k_q        <= '0;
            p_q        <= '0;
            r_q        <= '0;
            cnt_q      <= '0;
            out_q      <= '{x: '0, y: '0, zero: 1'b1};
            pa_reset_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            p_q        <= p_d;
            r_q        <= r_d;
            cnt_q      <= cnt_d;
            out_q      <= out_d;
            pa_reset_q <= pa_reset_d;
        end
    end

    assign last_bit = (cnt_q == CW'(1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (start) state_d = ST_DBL_START;
            ST_DBL_START: state_d = ST_DBL_WAIT;
            ST_DBL_WAIT: begin
                if (pa_done) begin
                    if (k_q[KW-1])    state_d = ST_ADD_START;
                    else if (last_bit) state_d = ST_FINISH;
                    else               state_d = ST_DBL_START;
                end
            end
            ST_ADD_START: state_d = ST_ADD_WAIT;
            ST_ADD_WAIT: begin
                if (pa_done) state_d = last_bit ? ST_FINISH : ST_DBL_START;
            end
            ST_FINISH:    state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    assign capture = pa_done && (state_q == ST_DBL_WAIT || state_q == ST_ADD_WAIT);
    assign advance = capture && !(state_q == ST_DBL_WAIT && k_q[KW-1]);

    always_comb begin
        k_d   = k_q;
        p_d   = p_q;
        r_d   = r_q;
        cnt_d = cnt_q;
        out_d = out_q;
        if (state_q == ST_IDLE && start) begin
            k_d   = k;
            p_d   = '{x: x, y: y, zero: zero};
            r_d   = '{x: '0, y: '0, zero: 1'b1};
            cnt_d = CW'(KW);
        end
        if (capture) r_d = pa_res;
        if (advance) begin
            k_d   = k_q << 1;
            cnt_d = cnt_q - 1'b1;
        end
        // Load the outputs on entry to FINISH so they are valid alongside done.
        if (state_d == ST_FINISH && state_q != ST_FINISH) out_d = r_d;
    end

    always_comb begin
        busy       = (state_q != ST_IDLE);
        done       = (state_q == ST_FINISH);
        pa_reset_d = is_start(state_d);
    end

    assign x_out    = out_q.x;
    assign y_out    = out_q.y;
    assign zero_out = out_q.zero;

endmodule
